leaky_relu_fwd_h_cache: RTL and testbench

- Forward-pass leaky ReLU column unit. Computes the activation of each incoming pre-activation value H.
- Captures every H value in a local buffer.
- Replays the captured H stream in order during the backward pass, feeding the H-data input of the leaky ReLU derivative unit in the same column.
- Sits between the systolic array column output and the unified buffer, one instance per column.

---
 rtl/tpu_pkg.sv | 30 +++
 rtl/leaky_relu_fwd_h_cache_buffer.sv | 48 ++++
 rtl/leaky_relu_fwd_h_cache.sv | 112 +++++++++++
 tb/tb_leaky_relu_fwd_h_cache.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared fixed-point types and helpers for the TPU column datapath.
package tpu_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;

    typedef logic signed [DATA_W-1:0] fxp16_t;

    localparam fxp16_t ONE  = 16'h0100;
    localparam fxp16_t ZERO = 16'h0000;

    typedef enum logic {
        IDLE,
        REPLAY
    } lr_cache_state_t;

    // Q8.8 multiply, round half up, saturate to the Q8.8 range.
    function automatic fxp16_t fxp_mul(input fxp16_t a, input fxp16_t b);
        logic signed [2*DATA_W-1:0] prod;
        logic signed [2*DATA_W-1:0] rnd;
        prod = a * b;
        rnd  = (prod + (int'(ONE) >>> 1)) >>> FRAC_BITS;
        if (rnd > 32'sd32767)
            return 16'sh7FFF;
        else if (rnd < -32'sd32768)
            return 16'sh8000;
        return fxp16_t'(rnd);
    endfunction

endpackage

// File: rtl/leaky_relu_fwd_h_cache_buffer.sv
// H capture register file: append-only write port, registered read port.
module lr_h_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH),
    parameter int CNT_W  = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     wr_addr;

    // A clear in the same cycle as a write restarts the cache at slot 0.
    assign wr_addr = clear ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (clear) begin
                wr_ptr <= wr_en ? AW'(1) : '0;
                count  <= wr_en ? CNT_W'(1) : '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + CNT_W'(1);
            end
            rd_data <= rd_en ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/leaky_relu_fwd_h_cache.sv
// Leaky ReLU forward column unit with an H cache replayed for backprop.
module leaky_relu_fwd_h_cache #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lr_valid_in,
    input  logic [DATA_W-1:0] lr_data_in,
    input  logic [DATA_W-1:0] lr_leak_factor_in,
    output logic              lr_valid_out,
    output logic [DATA_W-1:0] lr_data_out,
    input  logic              h_clear,
    input  logic              h_replay_start,
    output logic              h_valid_out,
    output logic [DATA_W-1:0] h_data_out,
    output logic              h_done,
    output logic [CNT_W-1:0]  h_count,
    output logic              h_full,
    output logic              h_drop
);

    import tpu_pkg::*;

    localparam int AW = $clog2(DEPTH);

    lr_cache_state_t state;
    logic [AW-1:0]   rd_ptr;
    logic            capture;
    logic            replay_last;
    logic            rd_en;
    logic            neg;

    assign neg         = lr_data_in[DATA_W-1];
    assign h_full      = (h_count == CNT_W'(DEPTH));
    assign capture     = lr_valid_in &&
                         (h_clear || (state == IDLE && !h_full));
    assign replay_last = (CNT_W'(rd_ptr) == h_count - CNT_W'(1));
    assign rd_en       = (state == REPLAY) && !h_clear;

    lr_h_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .CNT_W  (CNT_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clear   (h_clear),
        .wr_en   (capture),
        .wr_data (lr_data_in),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (h_data_out),
        .count   (h_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_valid_out <= 1'b0;
            lr_data_out  <= ZERO;
        end else begin
            lr_valid_out <= lr_valid_in;
            unique case (1'b1)
                !lr_valid_in:
                    lr_data_out <= ZERO;
                lr_valid_in && neg:
                    lr_data_out <= fxp_mul(lr_data_in, lr_leak_factor_in);
                lr_valid_in && !neg:
                    lr_data_out <= lr_data_in;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            h_valid_out <= 1'b0;
            h_done      <= 1'b0;
            h_drop      <= 1'b0;
        end else if (h_clear) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            h_valid_out <= 1'b0;
            h_done      <= 1'b0;
            h_drop      <= 1'b0;
        end else begin
            if (lr_valid_in && !capture)
                h_drop <= 1'b1;
            unique case (state)
                IDLE: begin
                    h_valid_out <= 1'b0;
                    h_done      <= 1'b0;
                    if (h_replay_start && h_count != '0) begin
                        state  <= REPLAY;
                        rd_ptr <= '0;
                    end
                end
                REPLAY: begin
                    h_valid_out <= 1'b1;
                    h_done      <= replay_last;
                    rd_ptr      <= rd_ptr + AW'(1);
                    if (replay_last)
                        state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leaky_relu_fwd_h_cache.sv
// Randomized scenario bench for leaky_relu_fwd_h_cache with a queue model.
module tb_leaky_relu_fwd_h_cache;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lr_valid_in = 1'b0;
    logic [15:0] lr_data_in = '0;
    logic [15:0] lr_leak_factor_in = '0;
    logic        lr_valid_out;
    logic [15:0] lr_data_out;
    logic        h_clear = 1'b0;
    logic        h_replay_start = 1'b0;
    logic        h_valid_out;
    logic [15:0] h_data_out;
    logic        h_done;
    logic [4:0]  h_count;
    logic        h_full;
    logic        h_drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_q[$];
    bit          m_busy = 0;
    int          m_idx  = 0;
    bit          m_drop = 0;
    logic        exp_lv = 0;
    logic [15:0] exp_ld = '0;
    logic        exp_hv = 0;
    logic [15:0] exp_hd = '0;
    logic        exp_done = 0;

    leaky_relu_fwd_h_cache dut (
        .clk               (clk),
        .rst               (rst),
        .lr_valid_in       (lr_valid_in),
        .lr_data_in        (lr_data_in),
        .lr_leak_factor_in (lr_leak_factor_in),
        .lr_valid_out      (lr_valid_out),
        .lr_data_out       (lr_data_out),
        .h_clear           (h_clear),
        .h_replay_start    (h_replay_start),
        .h_valid_out       (h_valid_out),
        .h_data_out        (h_data_out),
        .h_done            (h_done),
        .h_count           (h_count),
        .h_full            (h_full),
        .h_drop            (h_drop)
    );

    always #5 clk = ~clk;

    // Leaky ReLU in real arithmetic: x*leak, nearest with halves up, clamped.
    function automatic logic [15:0] act(input logic [15:0] d, input logic [15:0] lk);
        int  x;
        int  l;
        real r;
        x = int'($signed(d));
        l = int'($signed(lk));
        if (x >= 0) return d;
        r = $floor(real'(x) * real'(l) / 256.0 + 0.5);
        if (r > 32767.0) r = 32767.0;
        if (r < -32768.0) r = -32768.0;
        return 16'(int'(r));
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_idx = 0; m_drop = 0;
        exp_lv = 0; exp_ld = '0; exp_hv = 0; exp_hd = '0; exp_done = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d,
                              input logic [15:0] lk, input bit clr, input bit st);
        bit was_busy;
        was_busy = m_busy;
        exp_lv = v;
        exp_ld = v ? act(d, lk) : 16'h0000;
        if (clr) begin
            m_q.delete();
            m_busy = 0; m_drop = 0;
            exp_hv = 0; exp_hd = '0; exp_done = 0;
            if (v) m_q.push_back(d);
        end else begin
            if (m_busy) begin
                exp_hv   = 1;
                exp_hd   = m_q[m_idx];
                exp_done = (m_idx == m_q.size() - 1);
                m_idx++;
                if (exp_done) m_busy = 0;
            end else begin
                exp_hv = 0; exp_hd = '0; exp_done = 0;
                if (st && m_q.size() > 0) begin
                    m_busy = 1; m_idx = 0;
                end
            end
            if (v) begin
                if (!was_busy && m_q.size() < DEPTH) m_q.push_back(d);
                else m_drop = 1;
            end
        end
    endtask

    task automatic tick(input bit v, input logic [15:0] d, input logic [15:0] lk,
                        input bit clr, input bit st);
        lr_valid_in = v; lr_data_in = d; lr_leak_factor_in = lk;
        h_clear = clr; h_replay_start = st;
        @(posedge clk);
        model_step(v, d, lk, clr, st);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (lr_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_lr_valid got %b exp 0", lr_valid_out); end
        n_checks++; if (lr_data_out !== 16'h0) begin n_fail++; $display("FAIL reset_lr_data got %h exp 0000", lr_data_out); end
        n_checks++; if (h_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_h_valid got %b exp 0", h_valid_out); end
        n_checks++; if (h_data_out !== 16'h0) begin n_fail++; $display("FAIL reset_h_data got %h exp 0000", h_data_out); end
        n_checks++; if (h_done !== 1'b0) begin n_fail++; $display("FAIL reset_h_done got %b exp 0", h_done); end
        n_checks++; if (h_count !== 5'd0) begin n_fail++; $display("FAIL reset_h_count got %0d exp 0", h_count); end
        n_checks++; if (h_full !== 1'b0) begin n_fail++; $display("FAIL reset_h_full got %b exp 0", h_full); end
        n_checks++; if (h_drop !== 1'b0) begin n_fail++; $display("FAIL reset_h_drop got %b exp 0", h_drop); end
    endtask

    task automatic test_forward();
        logic [15:0] d;
        logic [15:0] lk;
        tick(0, 0, 16'h0080, 1, 0);
        tick(1, 16'h0300, 16'h0080, 0, 0);
        n_checks++; if (lr_valid_out !== 1'b1) begin n_fail++; $display("FAIL fwd_valid1 got %b exp 1", lr_valid_out); end
        n_checks++; if (lr_data_out !== 16'h0300) begin n_fail++; $display("FAIL fwd_pos got %h exp 0300", lr_data_out); end
        tick(1, 16'hFE00, 16'h0080, 0, 0);
        n_checks++; if (lr_data_out !== 16'hFF00) begin n_fail++; $display("FAIL fwd_neg got %h exp ff00", lr_data_out); end
        tick(0, 16'h1234, 16'h0080, 0, 0);
        n_checks++; if (lr_valid_out !== 1'b0) begin n_fail++; $display("FAIL fwd_valid0 got %b exp 0", lr_valid_out); end
        n_checks++; if (lr_data_out !== 16'h0000) begin n_fail++; $display("FAIL fwd_idle_data got %h exp 0000", lr_data_out); end
        n_checks++; if (h_count !== 5'd2) begin n_fail++; $display("FAIL fwd_count got %0d exp 2", h_count); end
        for (int i = 0; i < 24; i++) begin
            d  = 16'($urandom);
            lk = (i < 4) ? 16'h8000 : 16'($urandom);
            if (i == 0) d = 16'h8000;
            tick(1, d, lk, (i % 8) == 0, 0);
            n_checks++; if (lr_data_out !== exp_ld) begin n_fail++; $display("FAIL fwd_rand d=%h lk=%h got %h exp %h", d, lk, lr_data_out, exp_ld); end
        end
    endtask

    task automatic test_replay();
        logic [15:0] vals[4];
        logic [15:0] s1[$];
        logic [15:0] s2[$];
        int dones;
        vals = '{16'h0100, 16'hFF00, 16'h0000, 16'hFE80};
        tick(0, 0, 16'h0080, 1, 0);
        for (int i = 0; i < 4; i++) tick(1, vals[i], 16'h0080, 0, 0);
        tick(0, 0, 16'h0080, 0, 1);
        n_checks++; if (h_valid_out !== 1'b0) begin n_fail++; $display("FAIL replay_lag got %b exp 0", h_valid_out); end
        for (int r = 0; r < 2; r++) begin
            dones = 0;
            if (r == 1) tick(0, 0, 16'h0080, 0, 1);
            for (int i = 0; i < 6; i++) begin
                tick(0, 0, 16'h0080, 0, 0);
                n_checks++; if (h_valid_out !== exp_hv || h_data_out !== exp_hd || h_done !== exp_done) begin
                    n_fail++; $display("FAIL replay_beat r%0d c%0d got v%b %h d%b exp v%b %h d%b", r, i, h_valid_out, h_data_out, h_done, exp_hv, exp_hd, exp_done);
                end
                if (h_valid_out === 1'b1) begin
                    if (r == 0) s1.push_back(h_data_out); else s2.push_back(h_data_out);
                end
                if (h_done === 1'b1) dones++;
            end
            n_checks++; if (dones != 1) begin n_fail++; $display("FAIL replay_done_count got %0d exp 1", dones); end
        end
        n_checks++; if (s1.size() != 4) begin n_fail++; $display("FAIL replay_len got %0d exp 4", s1.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (i >= s1.size() || s1[i] !== vals[i]) begin n_fail++; $display("FAIL replay_order idx %0d exp %h", i, vals[i]); end
            n_checks++; if (i >= s2.size() || i >= s1.size() || s2[i] !== s1[i]) begin n_fail++; $display("FAIL replay_repeat idx %0d exp %h", i, vals[i]); end
        end
    endtask

    task automatic test_full();
        logic [15:0] d;
        logic [15:0] lk;
        tick(0, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            d  = 16'($urandom);
            lk = 16'($urandom_range(0, 16'h0100));
            tick(1, d, lk, 0, 0);
            n_checks++; if (lr_data_out !== exp_ld) begin n_fail++; $display("FAIL full_act %0d got %h exp %h", i, lr_data_out, exp_ld); end
            if (i == DEPTH - 2) begin
                n_checks++; if (h_full !== 1'b0) begin n_fail++; $display("FAIL full_early got %b exp 0", h_full); end
            end
            if (i == DEPTH - 1) begin
                n_checks++; if (h_full !== 1'b1 || h_drop !== 1'b0) begin n_fail++; $display("FAIL full_at16 got full %b drop %b exp 1 0", h_full, h_drop); end
            end
        end
        n_checks++; if (h_count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d exp 16", h_count); end
        n_checks++; if (h_drop !== 1'b1) begin n_fail++; $display("FAIL full_drop got %b exp 1", h_drop); end
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick(0, 0, 0, 0, 0);
            n_checks++; if (h_valid_out !== exp_hv || h_data_out !== exp_hd || h_done !== exp_done) begin
                n_fail++; $display("FAIL full_replay c%0d got v%b %h d%b exp v%b %h d%b", i, h_valid_out, h_data_out, h_done, exp_hv, exp_hd, exp_done);
            end
        end
    endtask

    task automatic test_clear_mid_replay();
        tick(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) tick(1, 16'(i * 16'h0111), 16'h0040, 0, 0);
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) tick(1, 16'hF000, 16'h0040, 0, 0);
        n_checks++; if (h_valid_out !== 1'b1 || h_data_out !== 16'h0222 || h_drop !== 1'b1) begin
            n_fail++; $display("FAIL clr_pre got v%b %h drop %b exp v1 0222 drop 1", h_valid_out, h_data_out, h_drop);
        end
        tick(0, 0, 0, 1, 1);
        n_checks++; if (h_valid_out !== 1'b0 || h_done !== 1'b0) begin n_fail++; $display("FAIL clr_valid got v%b d%b exp 0 0", h_valid_out, h_done); end
        n_checks++; if (h_count !== 5'd0) begin n_fail++; $display("FAIL clr_count got %0d exp 0", h_count); end
        n_checks++; if (h_drop !== 1'b0) begin n_fail++; $display("FAIL clr_drop got %b exp 0", h_drop); end
        tick(1, 16'h0505, 0, 1, 0);
        n_checks++; if (h_count !== 5'd1) begin n_fail++; $display("FAIL clr_with_capture got %0d exp 1", h_count); end
    endtask

    task automatic test_replay_capture();
        tick(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) tick(1, 16'h0010 + 16'(i), 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(1, 16'hFC00, 16'h0100, 0, 1);
        n_checks++; if (lr_valid_out !== 1'b1 || lr_data_out !== 16'hFC00) begin
            n_fail++; $display("FAIL rc_act got v%b %h exp v1 fc00", lr_valid_out, lr_data_out);
        end
        n_checks++; if (h_count !== 5'd3 || h_drop !== 1'b1) begin
            n_fail++; $display("FAIL rc_nocap got count %0d drop %b exp 3 1", h_count, h_drop);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0);
            n_checks++; if (h_valid_out !== exp_hv || h_data_out !== exp_hd || h_done !== exp_done) begin
                n_fail++; $display("FAIL rc_beat c%0d got v%b %h d%b exp v%b %h d%b", i, h_valid_out, h_data_out, h_done, exp_hv, exp_hd, exp_done);
            end
        end
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0);
            n_checks++; if (h_valid_out !== 1'b0) begin n_fail++; $display("FAIL empty_start c%0d got %b exp 0", i, h_valid_out); end
        end
    endtask

    task automatic test_reset_mid_replay();
        tick(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) tick(1, 16'h0700 + 16'(i), 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        tick(1, 16'h0123, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (lr_valid_out !== 1'b0 || lr_data_out !== 16'h0) begin n_fail++; $display("FAIL arst_fwd got v%b %h exp 0", lr_valid_out, lr_data_out); end
        n_checks++; if (h_valid_out !== 1'b0 || h_data_out !== 16'h0 || h_done !== 1'b0) begin n_fail++; $display("FAIL arst_h got v%b %h d%b exp 0", h_valid_out, h_data_out, h_done); end
        n_checks++; if (h_count !== 5'd0 || h_drop !== 1'b0) begin n_fail++; $display("FAIL arst_cache got %0d drop %b exp 0", h_count, h_drop); end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        tick(0, 0, 0, 0, 0);
        n_checks++; if (h_count !== 5'd0 || h_valid_out !== 1'b0) begin n_fail++; $display("FAIL arst_after got %0d v%b exp 0", h_count, h_valid_out); end
        tick(1, 16'h0042, 0, 0, 0);
        n_checks++; if (h_count !== 5'd1) begin n_fail++; $display("FAIL arst_idle_cap got %0d exp 1", h_count); end
    endtask

    task automatic test_back_to_back();
        bit v, clr, st;
        tick(0, 0, 0, 1, 0);
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom % 3) != 0;
            clr = ($urandom % 60) == 0;
            st  = ($urandom % 10) == 0;
            tick(v, 16'($urandom), 16'($urandom), clr, st);
            n_checks++; if (lr_valid_out !== exp_lv || lr_data_out !== exp_ld) begin
                n_fail++; $display("FAIL b2b_fwd c%0d got v%b %h exp v%b %h", i, lr_valid_out, lr_data_out, exp_lv, exp_ld);
            end
            n_checks++; if (h_valid_out !== exp_hv || h_data_out !== exp_hd || h_done !== exp_done) begin
                n_fail++; $display("FAIL b2b_h c%0d got v%b %h d%b exp v%b %h d%b", i, h_valid_out, h_data_out, h_done, exp_hv, exp_hd, exp_done);
            end
            n_checks++; if (h_count !== 5'(m_q.size()) || h_full !== (m_q.size() == DEPTH) || h_drop !== m_drop) begin
                n_fail++; $display("FAIL b2b_state c%0d got cnt %0d full %b drop %b exp %0d %b %b", i, h_count, h_full, h_drop, m_q.size(), m_q.size() == DEPTH, m_drop);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_forward();
        test_replay();
        test_full();
        test_clear_mid_replay();
        test_replay_capture();
        test_reset_mid_replay();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
